t5_fetch: RTL and testbench

Barrel-threaded instruction fetch unit for the t5 core, generalising the fixed four-hart fetch stage to `NHART` harts. Holds one program counter per hart, issues one fetch per cycle in strict round-robin hart order over a simple strobe/acknowledge instruction bus, and applies execute-stage branch redirects per hart. Sits between instruction memory and decode, and presents a registered instruction, PC and hart id to decode.

---
 rtl/t5_fetch.sv | 112 +++++++++++
 tb/tb_t5_fetch.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/t5_fetch.sv
// t5_fetch: barrel-threaded instruction fetch unit.
//
// Keeps one program counter per hart. It issues one fetch per cycle in strict
// round-robin hart order and registers the fetched word for decode. Branch
// redirects from execute are applied per hart. A redirect that targets the hart
// owning the current slot bypasses straight onto the fetch address.
//
// Parameters:
//   XLEN   data/address width
//   NHART  hart count (power of two, 2..8)
//   HW     hart id width
//   RESET  reset byte address of every hart (bits [1:0] ignored)
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   hmask           per-hart slot enable (only with T5_HART_MASK_EN)
//   ena             pipeline advance; low freezes all state
//   iadr, istb      fetch word address and request (combinational)
//   iack, idat      memory accept and instruction word (same cycle)
//   inst, pc, hid   registered instruction, its byte address and hart id
//   dval            inst/pc/hid valid
//   bra, bhid, alu  branch redirect strobe, target hart, target word address
//
// Optional feature macro: T5_HART_MASK_EN adds the hmask input. Masked slots
// are skipped but still consume their cycle, so slot timing stays fixed.
//
// Bus handshake: a fetch is transferred on a rising edge where istb && iack.
// The request carries no data from memory. When istb is high and iack is low,
// the same hart is requested again next cycle. iadr is held unless a bypassing
// branch arrives.

module t5_fetch #(
    parameter int              XLEN  = 32,
    parameter int              NHART = 4,
    parameter int              HW    = $clog2(NHART),
    parameter logic [XLEN-1:0] RESET = 32'h0
) (
    input  logic            clk,
    input  logic            rst,
`ifdef T5_HART_MASK_EN
    input  logic [NHART-1:0] hmask,
`endif
    input  logic            ena,
    output logic [XLEN-1:2] iadr,
    output logic            istb,
    input  logic            iack,
    input  logic [XLEN-1:0] idat,
    output logic [XLEN-1:0] inst,
    output logic [XLEN-1:0] pc,
    output logic [HW-1:0]   hid,
    output logic            dval,
    input  logic            bra,
    input  logic [HW-1:0]   bhid,
    input  logic [XLEN-1:2] alu
);

    logic [XLEN-1:2] pcf [NHART];
    logic [HW-1:0]   ptr;
    logic            slot_active;
    logic            bypass;
    logic            accept;

`ifdef T5_HART_MASK_EN
    assign slot_active = hmask[ptr];
`else
    assign slot_active = 1'b1;
`endif

    // A redirect for the hart that owns this slot must be used by this fetch.
    // pcf[ptr] still holds the stale path.
    assign bypass = bra && (bhid == ptr);
    assign iadr   = bypass ? alu : pcf[ptr];
    assign istb   = ena && !rst && slot_active;
    assign accept = istb && iack;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NHART; i++) begin
                pcf[i] <= RESET[XLEN-1:2];
            end
            ptr  <= '0;
            inst <= '0;
            pc   <= '0;
            hid  <= '0;
            dval <= 1'b0;
        end else if (ena) begin
            // The branch write comes first. When the same hart's fetch is
            // accepted, the increment below writes the same entry as alu+1
            // (iadr already equals alu), so the branch still wins.
            if (bra) begin
                pcf[bhid] <= alu;
            end

            if (accept) begin
                inst     <= idat;
                pc       <= {iadr, 2'b00};
                hid      <= ptr;
                dval     <= 1'b1;
                pcf[ptr] <= iadr + (XLEN-2)'(1);
                ptr      <= ptr + HW'(1);
            end else begin
                dval <= 1'b0;
                // A stalled slot retries the same hart. A masked slot is
                // passed over.
                if (!slot_active) begin
                    ptr <= ptr + HW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_t5_fetch.sv
// Bench for t5_fetch (NHART=4, RESET=0x100). The stimulus driver holds a
// per-hart PC model. It checks istb/iadr before every edge and queues the
// decode output each enabled cycle should produce. The monitor pops one entry
// per enabled edge and compares the decode register.

module tb_t5_fetch;

    localparam int          XLEN  = 32;
    localparam int          NHART = 4;
    localparam int          HW    = 2;
    localparam logic [31:0] RADR  = 32'h100;
    localparam int unsigned WMASK = 32'h3FFF_FFFF;
    localparam int          W     = 1 + 32 + 32 + HW;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            ena = 1'b0;
    logic            iack = 1'b0;
    logic [31:0]     idat = '0;
    logic            bra = 1'b0;
    logic [HW-1:0]   bhid = '0;
    logic [31:2]     alu = '0;
    logic [31:2]     iadr;
    logic            istb;
    logic [31:0]     inst;
    logic [31:0]     pc;
    logic [HW-1:0]   hid;
    logic            dval;
    logic [3:0]      mask_m = 4'hF;
`ifdef T5_HART_MASK_EN
    logic [3:0]      hmask = 4'hF;
`endif

    t5_fetch #(.XLEN(XLEN), .NHART(NHART), .RESET(RADR)) dut (
        .clk(clk), .rst(rst),
`ifdef T5_HART_MASK_EN
        .hmask(hmask),
`endif
        .ena(ena), .iadr(iadr), .istb(istb), .iack(iack), .idat(idat),
        .inst(inst), .pc(pc), .hid(hid), .dval(dval),
        .bra(bra), .bhid(bhid), .alu(alu)
    );

    always #5 clk = ~clk;

    // Reference state: word-address PC per hart and the current slot.
    int unsigned  pcw [NHART];
    int           slot = 0;
    logic [W-1:0] exp_q [$];
    int           n_vec = 0;
    int           n_err = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, expv, $time);
        end
    endtask

    // One clock cycle of stimulus. The model is advanced before the edge.
    task automatic cyc(input logic r, input logic e, input logic ak,
                       input logic b, input logic [HW-1:0] bh, input logic [31:2] a);
        int unsigned addr;
        logic        act;
        logic [31:0] dat;
        @(negedge clk);
        dat  = $urandom;
        rst  = r;
        ena  = e;
        iack = ak;
        bra  = b;
        bhid = bh;
        alu  = a;
        idat = dat;
`ifdef T5_HART_MASK_EN
        hmask = mask_m;
`endif
        #1;
        if (r) begin
            chk("istb_in_reset", 64'(istb), 64'(0));
            for (int i = 0; i < NHART; i++) pcw[i] = RADR >> 2;
            slot = 0;
            return;
        end
        addr = (b && int'(bh) == slot) ? 32'(a) : pcw[slot];
        chk("iadr", 64'(iadr), 64'(addr));
        if (!e) begin
            chk("istb_ena_low", 64'(istb), 64'(0));
            return;
        end
        act = mask_m[slot];
        chk("istb", 64'(istb), 64'(act));
        if (act && ak) begin
            exp_q.push_back({1'b1, dat, addr[29:0], 2'b00, HW'(slot)});
            if (b && int'(bh) != slot) pcw[bh] = 32'(a);
            pcw[slot] = (addr + 1) & WMASK;
            slot = (slot + 1) % NHART;
        end else begin
            exp_q.push_back({1'b0, 64'b0, HW'(0)});
            if (b) pcw[bh] = 32'(a);
            if (!act) slot = (slot + 1) % NHART;
        end
    endtask

    task automatic run(input int n, input logic ak);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b1, ak, 1'b0, '0, '0);
    endtask

    // Monitor. It keeps the expected decode register, which holds across
    // ena-low cycles and keeps inst/pc/hid through stalls.
    initial begin
        logic [31:0]   m_inst = '0;
        logic [31:0]   m_pc = '0;
        logic [HW-1:0] m_hid = '0;
        logic          m_dval = 1'b0;
        logic          r_e, e_e;
        logic [W-1:0]  ent;
        forever begin
            @(posedge clk);
            r_e = rst;
            e_e = ena;
            #1;
            if (r_e) begin
                m_inst = '0; m_pc = '0; m_hid = '0; m_dval = 1'b0;
            end else if (e_e) begin
                if (exp_q.size() == 0) begin
                    chk("queue_underflow", 64'(1), 64'(0));
                end else begin
                    ent = exp_q.pop_front();
                    m_dval = ent[W-1];
                    if (ent[W-1]) begin
                        m_inst = ent[65:34];
                        m_pc   = ent[33:2];
                        m_hid  = ent[1:0];
                    end
                end
            end
            chk("dval", 64'(dval), 64'(m_dval));
            chk("inst", 64'(inst), 64'(m_inst));
            chk("pc",   64'(pc),   64'(m_pc));
            chk("hid",  64'(hid),  64'(m_hid));
        end
    end

    initial begin
        cyc(1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
        cyc(1'b1, 1'b1, 1'b1, 1'b0, '0, '0);
        // Harts 0..3 fetch 0x40, then 0x41, from reset.
        run(10, 1'b1);
        // Stall in hart 2's slot for three cycles, then hart 2 and hart 3 deliver.
        run(3, 1'b0);
        run(2, 1'b1);
        // Reach slot 3, then redirect hart 1 to 0x80.
        run(3, 1'b1);
        cyc(1'b0, 1'b1, 1'b1, 1'b1, 2'd1, 30'h80);
        run(4, 1'b1);
        // Same-slot bypass with an accept, then without one.
        cyc(1'b0, 1'b1, 1'b1, 1'b1, HW'(slot), 30'h90);
        run(7, 1'b1);
        cyc(1'b0, 1'b1, 1'b0, 1'b1, HW'(slot), 30'h90);
        run(4, 1'b1);
        // ena low for two cycles, one with a branch pulse that must be ignored.
        cyc(1'b0, 1'b0, 1'b1, 1'b1, 2'd0, 30'h1234);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, '0, '0);
        run(4, 1'b1);
        // The top word address wraps to zero.
        cyc(1'b0, 1'b1, 1'b1, 1'b1, HW'(slot), 30'h3FFF_FFFF);
        run(5, 1'b1);
        // Reset in the middle of a stall.
        run(2, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 1'b1, 2'd1, 30'h55);
        run(8, 1'b1);
`ifdef T5_HART_MASK_EN
        mask_m = 4'b0101;
        run(8, 1'b1);
        cyc(1'b0, 1'b1, 1'b1, 1'b1, 2'd1, 30'h200);
        mask_m = 4'b0000;
        run(5, 1'b1);
        mask_m = 4'hF;
        run(3, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, '0, '0);
        run(8, 1'b1);
`endif
        // Randomized traffic.
        for (int i = 0; i < 1500; i++) begin
            logic [31:2] a;
            a = ($urandom_range(0, 3) == 0) ? 30'(WMASK - $urandom_range(0, 2))
                                            : 30'($urandom_range(0, 4095));
`ifdef T5_HART_MASK_EN
            if ($urandom_range(0, 49) == 0) mask_m = 4'($urandom);
`endif
            cyc($urandom_range(0, 99) == 0, $urandom_range(0, 9) != 0,
                $urandom_range(0, 3) != 0, $urandom_range(0, 5) == 0,
                HW'($urandom), a);
        end
        // Drain with ena low so nothing new is queued.
        cyc(1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
        chk("queue_empty", 64'(exp_q.size()), 64'(0));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
